// File: rtl/alu_pkg.sv
// Shared opcode map and controller state encoding for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // Opcode values; aliases keep the legacy decode holes explicit.
  localparam logic [31:0] OP_ADD    = 32'd0;
  localparam logic [31:0] OP_SUB    = 32'd1;
  localparam logic [31:0] OP_ADD2   = 32'd2;
  localparam logic [31:0] OP_SUB3   = 32'd3;
  localparam logic [31:0] OP_ADD4   = 32'd4;
  localparam logic [31:0] OP_ADD5   = 32'd5;
  localparam logic [31:0] OP_AND    = 32'd6;
  localparam logic [31:0] OP_OR     = 32'd7;
  localparam logic [31:0] OP_AND8   = 32'd8;
  localparam logic [31:0] OP_OR9    = 32'd9;
  localparam logic [31:0] OP_SLL    = 32'd10;
  localparam logic [31:0] OP_SRL    = 32'd11;
  localparam logic [31:0] OP_ONE    = 32'd12;
  localparam logic [31:0] OP_ONE13  = 32'd13;
  localparam logic [31:0] OP_NE     = 32'd14;
  localparam logic [31:0] OP_EQ     = 32'd15;
  localparam logic [31:0] OP_LEU    = 32'd16;
  localparam logic [31:0] OP_LTU    = 32'd17;
  localparam logic [31:0] OP_GEU    = 32'd18;
  localparam logic [31:0] OP_GTU    = 32'd19;
  localparam logic [31:0] OP_ZERO   = 32'd20;
  localparam logic [31:0] OP_ZERO21 = 32'd21;
  localparam logic [31:0] OP_ZERO22 = 32'd22;
  localparam logic [31:0] OP_LTU23  = 32'd23;
  localparam logic [31:0] OP_LTU24  = 32'd24;
  localparam logic [31:0] OP_MUL    = 32'd25;
  localparam logic [31:0] OP_SRA    = 32'd26;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, low WIDTH bits of a*b, one bit per cycle.
// Latency: operands captured on start edge, done/product valid during the WIDTH-th following cycle.
// Backpressure: none; the caller must consume product in the cycle done is high.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;

  // The final partial product is exposed combinationally so the caller can
  // register it on the same edge as the last iteration.
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign done     = running && (cnt == CW'(WIDTH - 1));
  assign product  = acc_step;

  // Capture operands on start, then consume one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc     <= acc_step;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/compare ops plus iterative MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL.
// Backpressure: result held while out_ready low; in_ready drops until it drains or MUL ends.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      op_ext;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] res;
  logic [SW-1:0]    shamt;
  logic             shift_big;
  logic             unused_instr;

  assign op_ext       = {{(32-OPW){1'b0}}, instr[31:32-OPW]};
  assign unused_instr = ^instr[31-OPW:0];
  assign is_mul       = (op_ext == OP_MUL);
  assign in_ready     = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign busy         = (state == ST_MUL);
  // Derived from the result register only, so it can never glitch on an intermediate.
  assign zero         = (c == '0);

  // WIDTH is a power of two, so any bit above the shift-amount field means b >= WIDTH.
  assign shamt     = b[SW-1:0];
  assign shift_big = |(b >> SW);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result decode; comparisons are unsigned and zero-extended.
  always_comb begin
    res = '0;
    case (op_ext)
      OP_ADD, OP_ADD2, OP_ADD4, OP_ADD5: res = a + b;
      OP_SUB, OP_SUB3:                   res = a - b;
      OP_AND, OP_AND8:                   res = a & b;
      OP_OR, OP_OR9:                     res = a | b;
      OP_SLL:  res = shift_big ? '0 : (a << shamt);
      OP_SRL:  res = shift_big ? '0 : (a >> shamt);
      OP_SRA:  res = shift_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> shamt);
      OP_ONE, OP_ONE13:                  res[0] = 1'b1;
      OP_NE:                             res[0] = (a != b);
      OP_EQ:                             res[0] = (a == b);
      OP_LEU:                            res[0] = (a <= b);
      OP_LTU, OP_LTU23, OP_LTU24:        res[0] = (a < b);
      OP_GEU:                            res[0] = (a >= b);
      OP_GTU:                            res[0] = (a > b);
      default:                           res = '0;
    endcase
  end

  // Next-state: leave IDLE only on a MUL accept, return when the last bit is consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)         state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Result register: load a new result (replacing any delivered one) or drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c         <= '0;
      out_valid <= 1'b0;
    end else if (accept && !is_mul) begin
      c         <= res;
      out_valid <= 1'b1;
    end else if ((state == ST_MUL) && mul_done) begin
      c         <= mul_product;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of a, b and c; legal values 8..64, powers of two.
REQ-002 Parameter OPW, default 6, SHALL set the opcode field width; the opcode SHALL be instr[31:32-OPW].
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  an operation is presented on instr/a/b.
REQ-006 in_ready  output  1  the block accepts an operation this cycle.
REQ-007 instr  input  32  instruction word; only the opcode field is decoded.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 out_valid  output  1  c/zero hold a result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 c  output  WIDTH  result.
REQ-012 zero  output  1  high when c equals 0.
REQ-013 busy  output  1  high while a multi-cycle operation is in progress.

Function
REQ-014 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-015 in_ready SHALL be high only when state is IDLE and (out_valid low or out_ready high).
REQ-016 Opcodes 0,2,4,5: c=a+b; 1,3: c=a-b; 6,8: a&b; 7,9: a|b; 10: a<<b; 11: a>>b (logical), all modulo 2^WIDTH.
REQ-017 Opcodes 12,13: c=1; 14: a!=b; 15: a==b; 16: a<=b; 17,23,24: a<b; 18: a>=b; 19: a>b; 20,21,22: c=0; comparisons are unsigned, result zero-extended to WIDTH.
REQ-018 New opcode 25 (MUL): c = low WIDTH bits of a*b (unsigned), computed iteratively, one bit per cycle.
REQ-019 New opcode 26 (SRA): c = a arithmetically shifted right by b.
REQ-020 Shifts SHALL use the full value of b; b>=WIDTH gives 0 for 10/11 and WIDTH copies of a[WIDTH-1] for 26.
REQ-021 Any opcode above 26 SHALL give c=0, zero=1 with single-cycle latency.
REQ-022 Single-cycle opcodes: accepted at edge N, out_valid high with result after edge N; throughput one per cycle when out_ready is held high.
REQ-023 MUL: accepted at edge N, busy high after edge N, out_valid high with result after edge N+WIDTH; in_ready low throughout.
REQ-024 States: IDLE -> (accept MUL) MUL -> (iteration counter reaches WIDTH-1) IDLE with result loaded; no other transitions.
REQ-025 out_valid, c and zero SHALL hold stable while out_valid high and out_ready low; out_valid SHALL drop on the edge where out_ready is high and no new result is loaded.
REQ-026 Result delivery and new acceptance in the same edge SHALL replace the result without a bubble.
REQ-027 zero SHALL be computed from the registered c, never from an intermediate.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid 0, busy 0, c 0, zero 1, iteration counter 0.
REQ-029 Reset during MUL SHALL abandon the operation; no result is produced after release.
REQ-030 in_ready SHALL be high on the first edge after rst_n deasserts.

Structure
REQ-031 Opcode constants (OP_ADD..OP_SRA) and the state enumeration SHALL live in shared package alu_pkg.
REQ-032 The iterative multiplier SHALL be sub-module alu_mul_iter (start, a, b -> done, product).

Verification
REQ-033 WIDTH=32, op 0, a=5, b=7, out_ready=1 -> c=12, zero=0, one cycle after accept.
REQ-034 op 1, a=3, b=3 -> c=0, zero=1; op 10, a=1, b=40 -> c=0.
REQ-035 op 25, a=0x0001_0003, b=0x0000_0010 -> busy 32 cycles, in_ready low, then c=0x0010_0030.
REQ-036 op 26, a=0x8000_0000, b=4 -> c=0xF800_0000; op 63 -> c=0, zero=1.
REQ-037 out_ready low for 5 cycles after result -> c/zero/out_valid stable, in_ready low; back-to-back ops with out_ready high -> one result per cycle.
REQ-038 rst_n pulsed low at MUL cycle 10 -> outputs at reset values immediately; no out_valid after release.
